// File: rtl/adcsnap_pkg.sv
// Shared types and constants for the ADC snapshot capture controller.
package adcsnap_pkg;

   localparam int unsigned CTRL_W = 32;
   localparam int unsigned STAT_W = 32;

   // Control register bit positions
   localparam int unsigned CTRL_ARM      = 0;
   localparam int unsigned CTRL_TRIG_NOW = 1;
   localparam int unsigned CTRL_VALID_EN = 2;

   // Status word bit positions (count occupies bits [ADDR_W:0])
   localparam int unsigned STAT_DONE  = 31;
   localparam int unsigned STAT_ARMED = 30;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/adcsnap_edge_det.sv
// Registered rising-edge detector.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   din      : level input
//   rise_c   : combinational pulse, high while din=1 and its previous sample was 0
module adcsnap_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise_c
);

   logic din_q;

   always_ff @(posedge clk) begin
      if (rst) din_q <= 1'b0;
      else     din_q <= din;
   end

   assign rise_c = din & ~din_q;

endmodule

// File: rtl/adcsnap_capture_ctrl.sv
// ADC snapshot capture controller: after a software arm and a trigger, writes
// 2^ADDR_W consecutive qualified samples into BRAM port A, then holds done.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   din/din_valid : ADC sample stream
//   trig          : external level trigger
//   ctrl          : bit0 arm (rising edge), bit1 trig_now, bit2 valid_en
//   bram_*        : registered port A write interface (en mirrors we)
//   status        : bit31 done, bit30 armed, [ADDR_W:0] words written
//   done          : capture complete
module adcsnap_capture_ctrl
   import adcsnap_pkg::*;
#(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   input  logic              trig,
   input  logic [CTRL_W-1:0] ctrl,
   output logic              bram_we,
   output logic              bram_en_a,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_wr_data,
   output logic [STAT_W-1:0] status,
   output logic              done
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_d, done_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] data_d;
   logic [STAT_W-1:0] status_d;
   logic              arm_pulse;
   logic              qual_valid;
   logic              start;

   logic unused_ctrl;
   assign unused_ctrl = ^ctrl[CTRL_W-1:CTRL_VALID_EN+1];

   // Arm acts on the rising edge of ctrl[0] only
   adcsnap_edge_det u_arm_edge (
      .clk    (clk),
      .rst    (rst),
      .din    (ctrl[CTRL_ARM]),
      .rise_c (arm_pulse)
   );

   assign qual_valid = ctrl[CTRL_VALID_EN] ? din_valid : 1'b1;
   assign start      = (trig | ctrl[CTRL_TRIG_NOW]) & qual_valid;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bram_we      <= 1'b0;
         bram_en_a    <= 1'b0;
         bram_addr    <= '0;
         bram_wr_data <= '0;
         status       <= '0;
         done         <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bram_we      <= we_d;
         bram_en_a    <= we_d;
         bram_addr    <= addr_d;
         bram_wr_data <= data_d;
         status       <= status_d;
         done         <= done_d;
      end
   end

   // Next state, counter and write request; arm pre-empts every state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = bram_addr;
      data_d  = bram_wr_data;
      done_d  = done;

      if (arm_pulse) begin
         state_d = ARMED;
         cnt_d   = '0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ARMED: begin
               if (start) begin
                  we_d    = 1'b1;
                  addr_d  = cnt_q[ADDR_W-1:0];
                  data_d  = din;
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = CAPTURE;
               end
            end
            CAPTURE: begin
               if (qual_valid) begin
                  we_d   = 1'b1;
                  addr_d = cnt_q[ADDR_W-1:0];
                  data_d = din;
                  cnt_d  = cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_ADDR) state_d = DONE;
               end
            end
            DONE: done_d = 1'b1;
            default: state_d = IDLE;
         endcase
      end
   end

   // Status word tracks the registered state/counter/done
   always_comb begin
      status_d             = '0;
      status_d[STAT_DONE]  = done_d;
      status_d[STAT_ARMED] = (state_d == ARMED);
      status_d[ADDR_W:0]   = cnt_d;
   end

endmodule

// File: tb/tb_adcsnap_capture_ctrl.sv
// Scoreboard bench for adcsnap_capture_ctrl: stimulus queues expected BRAM
// writes, a negedge monitor pops and compares each presented write.
module tb_adcsnap_capture_ctrl;

   localparam int unsigned DATA_W = 128;
   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              trig;
   logic [31:0]       ctrl;
   logic              bram_we;
   logic              bram_en_a;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wr_data;
   logic [31:0]       status;
   logic              done;

   adcsnap_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .din_valid    (din_valid),
      .trig         (trig),
      .ctrl         (ctrl),
      .bram_we      (bram_we),
      .bram_en_a    (bram_en_a),
      .bram_addr    (bram_addr),
      .bram_wr_data (bram_wr_data),
      .status       (status),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_w;
   int  n_pass  = 0;
   int  n_total = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DATA_W-1:0] pat(input int v);
      logic [31:0] w;
      w = 32'(v);
      return {4{w}};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input int a, input logic [DATA_W-1:0] d);
      wr_t w;
      w.addr = ADDR_W'(a);
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic chk_status(input string name, input logic [31:0] s, input logic d);
      @(negedge clk);
      chk({name, "_status"}, 128'(status), 128'(s));
      chk({name, "_done"},   128'(done),   128'(d));
   endtask

   // Write monitor
   always @(negedge clk) begin
      if (bram_we) begin
         chk("wr_en", 128'(bram_en_a), 128'(1));
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 128'(bram_we), 128'(0));
         end else begin
            mon_w = exp_q.pop_front();
            chk("wr_addr", 128'(bram_addr), 128'(mon_w.addr));
            chk("wr_data", bram_wr_data, mon_w.data);
         end
      end else if (bram_en_a) begin
         chk("idle_en", 128'(bram_en_a), 128'(0));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nw;
      rst = 1'b1; ctrl = 32'h0; din = '0; din_valid = 1'b0; trig = 1'b0;
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_we",     128'(bram_we),   128'(0));
      chk("rst_en",     128'(bram_en_a), 128'(0));
      chk("rst_addr",   128'(bram_addr), 128'(0));
      chk("rst_data",   bram_wr_data,    128'(0));
      chk("rst_status", 128'(status),    128'(0));
      chk("rst_done",   128'(done),      128'(0));
      rst = 1'b0;
      cyc();
      chk_status("idle", 32'h0, 1'b0);

      // Arm pulse then trig_now with continuous valid: full capture
      ctrl = 32'h1;
      cyc();
      chk_status("arm1", 32'h4000_0000, 1'b0);
      ctrl = 32'h3; din_valid = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         din = pat(1000 + i);
         expect_wr(i, pat(1000 + i));
         cyc();
      end
      chk_status("last_wr", 32'h0000_0400, 1'b0);
      din_valid = 1'b0;
      cyc();
      chk_status("t1_done", 32'h8000_0400, 1'b1);

      // Level-high arm after done must not re-arm
      din_valid = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         din = pat(k);
         cyc();
      end
      chk_status("hold_arm", 32'h8000_0400, 1'b1);
      ctrl = 32'h0;
      cyc();
      chk_status("drop_arm", 32'h8000_0400, 1'b1);
      ctrl = 32'h5;
      cyc();
      chk_status("rearm", 32'h4000_0000, 1'b0);

      // valid_en with toggling valid, trigger pulse at cycle 10
      for (int k = 0; k < 10; k++) begin
         trig = 1'b0; din_valid = (k % 2 == 0); din = pat(2000 + k);
         cyc();
      end
      chk_status("pretrig", 32'h4000_0000, 1'b0);
      nw = 0;
      for (int k = 0; nw < 1024; k++) begin
         trig = (k == 0); din_valid = (k % 2 == 0); din = pat(3000 + k);
         if (din_valid) begin
            expect_wr(nw, pat(3000 + k));
            nw++;
         end
         cyc();
      end
      trig = 1'b0; din_valid = 1'b0;
      cyc();
      chk_status("t2_done", 32'h8000_0400, 1'b1);

      // Trigger without valid is not latched
      ctrl = 32'h4;
      cyc();
      ctrl = 32'h5; din_valid = 1'b0;
      cyc();
      chk_status("t3_arm", 32'h4000_0000, 1'b0);
      trig = 1'b1; din_valid = 1'b0;
      repeat (3) cyc();
      trig = 1'b0; din_valid = 1'b1;
      repeat (5) cyc();
      chk_status("trig_novalid", 32'h4000_0000, 1'b0);

      // Re-arm after 300 words, coincident with a valid capture cycle
      trig = 1'b1; din_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         din = pat(4000 + i);
         expect_wr(i, pat(4000 + i));
         cyc();
      end
      chk_status("w300", 32'h0000_012C, 1'b0);
      trig = 1'b0; ctrl = 32'h4; din_valid = 1'b0;
      cyc();
      ctrl = 32'h5; din_valid = 1'b1; din = pat(9999);
      cyc();
      chk_status("rearm_mid", 32'h4000_0000, 1'b0);
      chk("rearm_mid_we", 128'(bram_we), 128'(0));
      trig = 1'b1; din = pat(5000);
      expect_wr(0, pat(5000));
      cyc();
      trig = 1'b0;
      chk_status("restart", 32'h0000_0001, 1'b0);
      for (int i = 1; i < 500; i++) begin
         din = pat(5000 + i);
         expect_wr(i, pat(5000 + i));
         cyc();
      end

      // Reset at word 500, then trigger alone does nothing
      rst = 1'b1; ctrl = 32'h4; din = pat(7777);
      cyc();
      @(negedge clk);
      chk("mrst_we",     128'(bram_we),   128'(0));
      chk("mrst_addr",   128'(bram_addr), 128'(0));
      chk("mrst_data",   bram_wr_data,    128'(0));
      chk("mrst_status", 128'(status),    128'(0));
      chk("mrst_done",   128'(done),      128'(0));
      rst = 1'b0; trig = 1'b1; din_valid = 1'b1;
      repeat (5) cyc();
      chk_status("post_rst", 32'h0, 1'b0);
      trig = 1'b0;
      cyc();

      chk("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
